acc_mem_arbiter: RTL and testbench
==================================

// Module: acc_mem_arbiter
// PURPOSE
//  Owns the single data-memory port (d_mem: 64 x 32, sync write, comb read) and shares it between the
//  pipelined MIPS core and the accelerator read-burst engine. On an accelerator start it sequences a
//  burst of word reads from startaddr for datasize words, streams them to the accelerator over a
//  valid/ready interface, and pulses done. Sits between mipspipelined and d_mem in the top level.
// PARAMETERS
//  AW  6   word-address width of d_mem (depth 2**AW)
//  DW  32  data width
// PORTS
//  clk            in   1   clock, all state on rising edge
//  reset          in   1   asynchronous, active-high reset
//  cpu_memreq     in   1   core load or store this cycle
//  cpu_memwrite   in   1   core store (qualified by cpu_memreq)
//  cpu_addr       in   AW  core word address
//  cpu_wdata      in   DW  core store data
//  cpu_rdata      out  DW  core load data (comb from mem_rdata)
//  cpu_stall      out  1   core must hold its memory stage
//  acc_start      in   1   one-cycle burst request
//  acc_bypass     in   1   accelerator bypassed: start completes with no burst
//  acc_startaddr  in   AW  first word address of burst
//  acc_datasize   in   AW  burst length in words (0 = empty burst)
//  acc_busy       out  1   burst in progress (state != IDLE)
//  acc_done       out  1   one-cycle completion pulse
//  acc_rdata      out  DW  streamed word
//  acc_rvalid     out  1   acc_rdata valid
//  acc_rready     in   1   accelerator accepts word
//  mem_we         out  1   d_mem write enable
//  mem_addr       out  AW  d_mem word address
//  mem_wdata      out  DW  d_mem write data
//  mem_rdata      in   DW  d_mem read data (comb)
// BEHAVIOUR
//  Reset: state=IDLE; acc_busy, acc_done, acc_rvalid, mem_we, cpu_stall = 0; acc_rdata=0; ptr/count=0.
//  FSM IDLE -> BURST -> DRAIN -> DONE -> IDLE.
//  IDLE: acc_start & !acc_bypass & datasize!=0: latch ptr=startaddr, count=datasize -> BURST.
//   acc_start & (acc_bypass | datasize==0): acc_done pulses next cycle, stay IDLE. acc_start when not IDLE ignored.
//  Grant: acc_grant = (state==BURST) & (!acc_rvalid | acc_rready) & !cpu_memreq.
//   acc_grant: mem_addr=ptr, mem_we=0; else mem_addr=cpu_addr, mem_we=cpu_memreq&cpu_memwrite&!cpu_stall.
//  On acc_grant: acc_rdata<=mem_rdata, acc_rvalid<=1, ptr<=ptr+1 (wraps mod 2**AW), count<=count-1;
//   count reaching 0 -> DRAIN. Word valid 1 cycle after grant; max 1 word/cycle.
//  acc_rvalid & acc_rready & !acc_grant: acc_rvalid<=0. acc_rdata held stable while valid & !ready.
//  DRAIN: when last word accepted (rvalid & rready) -> DONE. DONE: acc_done=1 one cycle -> IDLE.
//  Ordering: core store in same cycle as acc_start lands before burst; core store during burst to an
//   unread address is seen by the burst.
//  Reset mid-burst: immediate return to IDLE, rvalid dropped, no done pulse.
// CONFIGURATION
//  BURST_PRIO_EN undefined: core has priority; cpu_stall tied 0; burst uses idle memory cycles only.
//  BURST_PRIO_EN defined: burst owns memory in BURST; cpu_stall = cpu_memreq & (state==BURST);
//   acc_grant drops the !cpu_memreq term; stalled stores never reach mem_we.
// STRUCTURE
//  Package acc_mem_pkg: AW/DW defaults, state enum {IDLE,BURST,DRAIN,DONE}.
//  Sub-module acc_out_reg: one-entry valid/ready output register (load, rdata, rvalid, rready).
// TESTING
//  start addr=4 size=3, rready=1, no core traffic -> words mem[4],mem[5],mem[6] on 3 consecutive cycles; done 2 cycles after last.
//  start addr=62 size=4 -> mem[62],mem[63],mem[0],mem[1]; ptr wraps, done once.
//  size=3, rready low 5 cycles after first word -> rdata held mem[a], no ptr advance; resumes in order.
//  size=0 or acc_bypass=1 -> acc_done pulse next cycle, acc_busy never high, no rvalid.
//  burst with core load every cycle -> no default: burst stalls, cpu_stall=0; BURST_PRIO_EN: cpu_stall=1, burst finishes in size cycles.
//  reset asserted mid-burst -> all outputs to reset values same cycle; new start then works normally.

Source files
------------

// File: rtl/acc_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : acc_mem_pkg
// Description : Shared defaults and FSM state type for the accelerator /
//               data-memory arbiter.
//               AW_DEF - default word-address width of d_mem (depth 2**AW)
//               DW_DEF - default data width
//               acc_state_t - burst sequencer states
// Revision    : 1.0 - initial release
// ============================================================================
package acc_mem_pkg;

  localparam int AW_DEF = 6;
  localparam int DW_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } acc_state_t;

endpackage
`default_nettype wire

// File: rtl/acc_out_reg.sv
`default_nettype none
// ============================================================================
// Module      : acc_out_reg
// Description : One-entry valid/ready output register feeding the
//               accelerator. A load captures a word and raises valid; the
//               word is held stable until the consumer accepts it.
// Ports       : clk      - clock
//               reset    - asynchronous active-high reset
//               i_load   - capture i_data this cycle
//               i_data   - word to capture
//               i_rready - consumer accepts the current word
//               o_rvalid - o_rdata holds a valid word
//               o_rdata  - held word
// Revision    : 1.0 - initial release
// ============================================================================
module acc_out_reg
  import acc_mem_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_load,
  input  logic [DW-1:0] i_data,
  input  logic          i_rready,
  output logic          o_rvalid,
  output logic [DW-1:0] o_rdata
);

  logic          r_valid;
  logic [DW-1:0] r_data;

  // A load takes precedence over a drain: the caller only loads when the
  // slot is empty or being emptied this same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (r_valid && i_rready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_rvalid = r_valid;
  assign o_rdata  = r_data;

endmodule
`default_nettype wire

// File: rtl/acc_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : acc_mem_arbiter
// Description : Owns the single d_mem port and shares it between the
//               pipelined core and the accelerator read-burst engine. An
//               accelerator start reads datasize words from startaddr,
//               streams them over valid/ready and pulses done.
// Ports       : clk / reset          - clock, async active-high reset
//               i_cpu_*  / o_cpu_*   - core load/store port and stall
//               i_acc_*  / o_acc_*   - burst control, status and stream
//               o_mem_* / i_mem_rdata - d_mem port (sync write, comb read)
// Config      : BURST_PRIO_EN - when defined the burst owns the memory in
//               BURST and the core is stalled; otherwise the core has
//               priority and the burst uses idle memory cycles only.
// Revision    : 1.0 - initial release
// ============================================================================
module acc_mem_arbiter
  import acc_mem_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_cpu_memreq,
  input  logic          i_cpu_memwrite,
  input  logic [AW-1:0] i_cpu_addr,
  input  logic [DW-1:0] i_cpu_wdata,
  output logic [DW-1:0] o_cpu_rdata,
  output logic          o_cpu_stall,
  input  logic          i_acc_start,
  input  logic          i_acc_bypass,
  input  logic [AW-1:0] i_acc_startaddr,
  input  logic [AW-1:0] i_acc_datasize,
  output logic          o_acc_busy,
  output logic          o_acc_done,
  output logic [DW-1:0] o_acc_rdata,
  output logic          o_acc_rvalid,
  input  logic          i_acc_rready,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  input  logic [DW-1:0] i_mem_rdata
);

  acc_state_t    r_state;
  logic [AW-1:0] r_ptr;
  logic [AW-1:0] r_count;
  logic          r_busy;
  logic          r_done;

  logic w_burst;
  logic w_grant;
  logic w_stall;
  logic w_rvalid;
  logic w_slot_free;

  assign w_burst     = (r_state == BURST);
  // The output slot can take a new word if empty or emptied this cycle.
  assign w_slot_free = !w_rvalid || i_acc_rready;

`ifdef BURST_PRIO_EN
  assign w_stall = i_cpu_memreq & w_burst;
  assign w_grant = w_burst & w_slot_free;
`else
  assign w_stall = 1'b0;
  assign w_grant = w_burst & w_slot_free & !i_cpu_memreq;
`endif

  // Memory port mux; a stalled core store must never reach the memory.
  assign o_mem_addr  = w_grant ? r_ptr : i_cpu_addr;
  assign o_mem_we    = !w_grant & i_cpu_memreq & i_cpu_memwrite & !w_stall;
  assign o_mem_wdata = i_cpu_wdata;
  assign o_cpu_rdata = i_mem_rdata;
  assign o_cpu_stall = w_stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_acc_start) begin
            if (!i_acc_bypass && (i_acc_datasize != '0)) begin
              r_ptr   <= i_acc_startaddr;
              r_count <= i_acc_datasize;
              r_state <= BURST;
              r_busy  <= 1'b1;
            end else begin
              // Nothing to fetch: complete immediately without a burst.
              r_done <= 1'b1;
            end
          end
        end
        BURST: begin
          if (w_grant) begin
            r_ptr   <= r_ptr + 1'b1;  // wraps modulo the memory depth
            r_count <= r_count - 1'b1;
            if (r_count == AW'(1)) begin
              r_state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // Last word is still in the output slot; wait for its acceptance.
          if (w_rvalid && i_acc_rready) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  acc_out_reg #(
    .DW (DW)
  ) u_out_reg (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_grant),
    .i_data   (i_mem_rdata),
    .i_rready (i_acc_rready),
    .o_rvalid (w_rvalid),
    .o_rdata  (o_acc_rdata)
  );

  assign o_acc_rvalid = w_rvalid;
  assign o_acc_busy   = r_busy;
  assign o_acc_done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_acc_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_acc_mem_arbiter
// Description : Self-checking bench for acc_mem_arbiter with a d_mem model,
//               a shadow copy of memory contents and a queue of expected
//               burst words derived from start address and length.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_acc_mem_arbiter;

  localparam int AW    = 6;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_cpu_memreq;
  logic          i_cpu_memwrite;
  logic [AW-1:0] i_cpu_addr;
  logic [DW-1:0] i_cpu_wdata;
  logic [DW-1:0] o_cpu_rdata;
  logic          o_cpu_stall;
  logic          i_acc_start;
  logic          i_acc_bypass;
  logic [AW-1:0] i_acc_startaddr;
  logic [AW-1:0] i_acc_datasize;
  logic          o_acc_busy;
  logic          o_acc_done;
  logic [DW-1:0] o_acc_rdata;
  logic          o_acc_rvalid;
  logic          i_acc_rready;
  logic          o_mem_we;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_wdata;
  logic [DW-1:0] i_mem_rdata;

  always #5 clk = ~clk;

  acc_mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk             (clk),
    .reset           (reset),
    .i_cpu_memreq    (i_cpu_memreq),
    .i_cpu_memwrite  (i_cpu_memwrite),
    .i_cpu_addr      (i_cpu_addr),
    .i_cpu_wdata     (i_cpu_wdata),
    .o_cpu_rdata     (o_cpu_rdata),
    .o_cpu_stall     (o_cpu_stall),
    .i_acc_start     (i_acc_start),
    .i_acc_bypass    (i_acc_bypass),
    .i_acc_startaddr (i_acc_startaddr),
    .i_acc_datasize  (i_acc_datasize),
    .o_acc_busy      (o_acc_busy),
    .o_acc_done      (o_acc_done),
    .o_acc_rdata     (o_acc_rdata),
    .o_acc_rvalid    (o_acc_rvalid),
    .i_acc_rready    (i_acc_rready),
    .o_mem_we        (o_mem_we),
    .o_mem_addr      (o_mem_addr),
    .o_mem_wdata     (o_mem_wdata),
    .i_mem_rdata     (i_mem_rdata)
  );

  // d_mem: synchronous write, combinational read
  logic [DW-1:0] mem [DEPTH];
  assign i_mem_rdata = mem[o_mem_addr];
  always @(posedge clk) if (o_mem_we) mem[o_mem_addr] <= o_mem_wdata;

  // Reference state
  logic [DW-1:0] shadow [DEPTH];
  logic [DW-1:0] exp_q [$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int words_cnt, first_cyc, last_cyc, done_cyc, start_cyc;
  bit busy_seen, rvalid_seen;
  logic          hold_pend = 1'b0;
  logic [DW-1:0] hold_data;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Output monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (reset) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        check("hold_valid", 32'(o_acc_rvalid), 32'd1);
        check("hold_data", o_acc_rdata, hold_data);
      end
      hold_pend = o_acc_rvalid && !i_acc_rready;
      hold_data = o_acc_rdata;
      if (o_acc_rvalid && i_acc_rready) begin
        check("word_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("burst_word", o_acc_rdata, exp_q.pop_front());
        if (words_cnt == 0) first_cyc = cyc;
        last_cyc = cyc;
        words_cnt++;
      end
      if (o_acc_done) begin
        done_cnt++;
        done_cyc = cyc;
        check("queue_empty_at_done", 32'(exp_q.size()), 32'd0);
      end
      if (o_acc_busy) busy_seen = 1'b1;
      if (o_acc_rvalid) rvalid_seen = 1'b1;
      if (i_cpu_memreq && !i_cpu_memwrite && !o_cpu_stall)
        check("cpu_rdata", o_cpu_rdata, shadow[i_cpu_addr]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [AW-1:0] a, input logic [DW-1:0] d);
    i_cpu_memreq   = 1'b1;
    i_cpu_memwrite = 1'b1;
    i_cpu_addr     = a;
    i_cpu_wdata    = d;
    shadow[a]      = d;
    tick();
    i_cpu_memreq   = 1'b0;
    i_cpu_memwrite = 1'b0;
  endtask

  // Expected stream: consecutive words from a, wrapping at the top of memory.
  task automatic start_burst(input logic [AW-1:0] a, input logic [AW-1:0] n, input bit byp);
    i_acc_startaddr = a;
    i_acc_datasize  = n;
    i_acc_bypass    = byp;
    i_acc_start     = 1'b1;
    start_cyc       = cyc;
    if (!byp)
      for (int i = 0; i < int'(n); i++) exp_q.push_back(shadow[(int'(a) + i) % DEPTH]);
    tick();
    i_acc_start  = 1'b0;
    i_acc_bypass = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int k = 0;
    while (done_cnt < target && k < budget) begin
      tick();
      k++;
    end
    check("done_count", done_cnt, target);
  endtask

  int            base;
  logic [DW-1:0] d1, d2;
  logic [AW-1:0] ra, rn;
  bit            rb;

  initial begin
    reset           = 1'b1;
    i_cpu_memreq    = 1'b0;
    i_cpu_memwrite  = 1'b0;
    i_cpu_addr      = '0;
    i_cpu_wdata     = '0;
    i_acc_start     = 1'b0;
    i_acc_bypass    = 1'b0;
    i_acc_startaddr = '0;
    i_acc_datasize  = '0;
    i_acc_rready    = 1'b1;
    words_cnt       = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy",   32'(o_acc_busy),   32'd0);
    check("rst_done",   32'(o_acc_done),   32'd0);
    check("rst_rvalid", 32'(o_acc_rvalid), 32'd0);
    check("rst_rdata",  o_acc_rdata,       32'd0);
    check("rst_mem_we", 32'(o_mem_we),     32'd0);
    check("rst_stall",  32'(o_cpu_stall),  32'd0);
    tick();
    reset = 1'b0;
    tick();

    // Fill memory through the core store path
    for (int i = 0; i < DEPTH; i++) store(AW'(i), $urandom);

    // Basic burst: three words back to back, done two cycles after the last
    base = done_cnt; words_cnt = 0;
    start_burst(6'd4, 6'd3, 1'b0);
    wait_done(base + 1, 50);
    repeat (3) tick();
    check("t1_words", words_cnt, 3);
    check("t1_first_lat", first_cyc - start_cyc, 2);
    check("t1_span", last_cyc - first_cyc, 2);
    check("t1_done_lat", done_cyc - last_cyc, 2);
    check("t1_done_once", done_cnt, base + 1);

    // Address wrap
    base = done_cnt; words_cnt = 0;
    start_burst(6'd62, 6'd4, 1'b0);
    wait_done(base + 1, 50);
    repeat (3) tick();
    check("t2_words", words_cnt, 4);
    check("t2_done_once", done_cnt, base + 1);

    // Back-pressure after the first word
    base = done_cnt; words_cnt = 0;
    i_acc_rready = 1'b0;
    start_burst(6'd10, 6'd3, 1'b0);
    for (int k = 0; k < 20 && !o_acc_rvalid; k++) tick();
    check("t3_first_valid", 32'(o_acc_rvalid), 32'd1);
    repeat (5) tick();
    check("t3_no_advance", 32'(exp_q.size()), 32'd3);
    i_acc_rready = 1'b1;
    wait_done(base + 1, 50);
    repeat (2) tick();
    check("t3_words", words_cnt, 3);

    // Empty burst and bypass: immediate done, no busy, no data
    busy_seen = 1'b0; rvalid_seen = 1'b0;
    start_burst(6'd20, 6'd0, 1'b0);
    check("t4_size0_done", 32'(o_acc_done), 32'd1);
    tick();
    check("t4_size0_done_low", 32'(o_acc_done), 32'd0);
    start_burst(6'd20, 6'd5, 1'b1);
    check("t4_bypass_done", 32'(o_acc_done), 32'd1);
    tick();
    check("t4_bypass_done_low", 32'(o_acc_done), 32'd0);
    tick();
    check("t4_busy_seen", 32'(busy_seen), 32'd0);
    check("t4_rvalid_seen", 32'(rvalid_seen), 32'd0);

    // Core load every cycle during a burst
    base = done_cnt; words_cnt = 0;
    i_cpu_memreq = 1'b1; i_cpu_memwrite = 1'b0; i_cpu_addr = AW'($urandom);
    start_burst(6'd30, 6'd4, 1'b0);
`ifdef BURST_PRIO_EN
    for (int k = 0; k < 4; k++) begin
      check("t5_stall", 32'(o_cpu_stall), 32'd1);
      i_cpu_addr = AW'($urandom);
      tick();
    end
    check("t5_stall_released", 32'(o_cpu_stall), 32'd0);
    tick();
    check("t5_words_in_size", words_cnt, 4);
`else
    for (int k = 0; k < 6; k++) begin
      check("t5_no_stall", 32'(o_cpu_stall), 32'd0);
      i_cpu_addr = AW'($urandom);
      tick();
    end
    check("t5_starved", words_cnt, 0);
`endif
    i_cpu_memreq = 1'b0;
    wait_done(base + 1, 50);
    repeat (2) tick();
    check("t5_words", words_cnt, 4);

    // Ordering of core stores relative to the burst
    base = done_cnt; words_cnt = 0;
    d1 = $urandom; d2 = $urandom;
    i_cpu_memreq = 1'b1; i_cpu_memwrite = 1'b1; i_cpu_addr = 6'd40; i_cpu_wdata = d1;
    shadow[40] = d1;
    start_burst(6'd40, 6'd8, 1'b0);
`ifdef BURST_PRIO_EN
    i_cpu_memreq = 1'b0; i_cpu_memwrite = 1'b0;
`else
    exp_q[7] = d2;
    store(6'd47, d2);
`endif
    wait_done(base + 1, 80);
    repeat (2) tick();
    check("t6_words", words_cnt, 8);

    // Reset in the middle of a burst
    start_burst(6'd50, 6'd10, 1'b0);
    repeat (3) tick();
    reset = 1'b1;
    #1;
    check("t7_busy",   32'(o_acc_busy),   32'd0);
    check("t7_rvalid", 32'(o_acc_rvalid), 32'd0);
    check("t7_rdata",  o_acc_rdata,       32'd0);
    check("t7_done",   32'(o_acc_done),   32'd0);
    check("t7_stall",  32'(o_cpu_stall),  32'd0);
    exp_q.delete();
    base = done_cnt;
    tick();
    reset = 1'b0;
    repeat (4) tick();
    check("t7_no_done", done_cnt, base);
    words_cnt = 0;
    start_burst(6'd3, 6'd5, 1'b0);
    wait_done(base + 1, 50);
    repeat (2) tick();
    check("t7_after_words", words_cnt, 5);

    // Randomized bursts with back-pressure and core loads
    for (int it = 0; it < 15; it++) begin
      ra = AW'($urandom);
      rn = AW'($urandom_range(0, 12));
      rb = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 1) == 1) store(AW'($urandom), $urandom);
      base = done_cnt;
      start_burst(ra, rn, rb);
      for (int k = 0; k < 300 && done_cnt == base; k++) begin
        i_acc_rready   = ($urandom_range(0, 9) < 7);
        i_cpu_memreq   = ($urandom_range(0, 9) < 3);
        i_cpu_memwrite = 1'b0;
        i_cpu_addr     = AW'($urandom);
        tick();
      end
      i_cpu_memreq = 1'b0;
      i_acc_rready = 1'b1;
      check("rand_done", done_cnt, base + 1);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
